led_frame_sched: RTL
====================

Name: led_frame_sched

Overview:
- Sequences the MiniLED driver write interface: power-up config wait, periodic sdbpflag strobe, then a burst of per-zone brightness words.
- Owns the zone-grayscale ping-pong buffer. It reads the front bank and swaps banks only on frame boundaries, using a handshake with the upstream zone-statistics producer.
- Sits between the zone buffer and the LED driver serializer.

Parameters:
- ZONES, 360, number of LED zones per frame
- CFG_WAIT, 2500, clk cycles after reset before the first frame (driver register config time)
- PERIOD, 420000, clk cycles per frame period; must be greater than FLAG_W+ZONES+4
- FLAG_W, 30, o_sdbpflag high time in clk cycles
- ADDR_W, 10, width of zone address

Ports:
- clk  in  1  25 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  allow new frames to start
- i_mode  in  2  00 full backlight, 01 zone*255, 10 zone*gain, 11 full-white test
- i_gain  in  8  brightness gain for mode 10
- i_frame_rdy  in  1  producer has completed the back bank; level held until ack
- o_frame_ack  out  1  1-cycle pulse: back bank accepted, banks swapped
- o_rd_bank  out  1  bank index read by this block; producer writes ~o_rd_bank
- o_rd_en  out  1  zone buffer read strobe
- o_rd_addr  out  ADDR_W  zone buffer read address 0..ZONES-1
- i_rd_data  in  8  zone grayscale, valid 1 cycle after o_rd_en
- o_cfg_done  out  1  config wait elapsed (sticky until reset)
- o_sdbpflag  out  1  driver frame-start flag
- o_wt_valid  out  1  o_wtaddr/o_wtdina valid
- o_wtaddr  out  ADDR_W  driver zone address 1..ZONES
- o_wtdina  out  16  driver brightness word
- o_busy  out  1  frame in progress

Behaviour:
- Reset (async, any time including mid-burst):
  - All outputs go to 0; o_rd_bank=0.
  - FSM returns to S_CFG and all counters clear. The config wait restarts on release.
- S_CFG:
  - Counter runs 0..CFG_WAIT-1.
  - o_cfg_done rises registered on the cycle after the count reaches CFG_WAIT-1, and stays high.
  - Transition to S_IDLE.
- Period counter pcnt:
  - Runs 0..PERIOD-1, wraps, and starts at 0 on the first cycle o_cfg_done=1.
  - Free-running regardless of i_enable.
  - tick = (pcnt==0).
- S_IDLE:
  - On tick with i_enable=1, go to S_FLAG. Tick with i_enable=0 is skipped; no flag, no swap.
  - On that same tick edge, i_mode and i_gain are latched for the frame.
  - On that same tick edge, if i_frame_rdy=1, o_rd_bank toggles and o_frame_ack pulses high for the first S_FLAG cycle.
  - Banks never swap at any other time.
- S_FLAG: o_sdbpflag=1 for exactly FLAG_W cycles, then S_BURST.
- S_BURST:
  - o_rd_en=1 for ZONES consecutive cycles; o_rd_addr = 0,1,...,ZONES-1.
  - Then S_DRAIN for 2 cycles, then S_IDLE.
- Output pipeline:
  - For the read at address k, o_wt_valid=1 with o_wtaddr=k+1 two cycles after the o_rd_en cycle.
  - o_wtdina is registered from i_rd_data using the latched mode:
    - 00: 57120 (0xE0*255)
    - 01: data*255
    - 10: data*gain
    - 11: 0xFFFF
  - Products are 8x8 unsigned into 16 bits; no overflow or saturation is needed.
  - When o_wt_valid=0: o_wtaddr=0 and o_wtdina=0.
- o_busy=1 in S_FLAG, S_BURST and S_DRAIN.
- Frame length and period:
  - Frame length is FLAG_W+ZONES+2 cycles, which is always less than PERIOD.
  - A tick therefore always finds S_IDLE.
  - Mid-frame i_enable deassertion does not abort; the frame completes.
- i_mode/i_gain changes mid-frame have no effect until the next tick.
- i_frame_rdy deasserting without ack is legal; no swap occurs.

Test Plan:
Parameters for all scenarios: CFG_WAIT=10, PERIOD=500, FLAG_W=30, ZONES=360.
- Reset release, i_enable=1 -> o_cfg_done rises at cycle 11; o_sdbpflag high for exactly 30 cycles starting 1 cycle after the first tick; o_wt_valid high for 360 cycles with o_wtaddr 1..360; next o_sdbpflag 500 cycles after the first.
- Mode 10, i_gain=128, i_rd_data=addr[7:0] -> o_wtdina for wtaddr 201 equals 200*128=25600; o_wtdina=0 outside the burst.
- Mode 00 -> every valid word is 57120. Mode 11 -> every valid word is 0xFFFF. i_mode switched to 01 mid-burst -> the current frame is unchanged and the next frame uses data*255.
- i_frame_rdy asserted mid-burst -> no swap until the next tick; then o_rd_bank toggles and o_frame_ack is a single pulse. i_frame_rdy low at tick -> o_rd_bank holds.
- i_enable low across 2 ticks -> no o_sdbpflag and no swap; pcnt keeps running and frames resume on the next tick after i_enable returns high.
- rst_n asserted at zone 150 of a burst -> all outputs 0 immediately; after release o_cfg_done stays low for 10 cycles, and o_rd_bank=0.

Source files
------------

// File: rtl/led_frame_sched_if.sv
// Zone-buffer side of the frame scheduler: bank handshake with the
// statistics producer plus the grayscale read port of the ping-pong buffer.
interface led_frame_sched_if #(
    parameter int ADDR_W = 10
) ();
    logic              i_frame_rdy;
    logic              o_frame_ack;
    logic              o_rd_bank;
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic [7:0]        i_rd_data;

    // Scheduler side
    modport master (
        input  i_frame_rdy,
        input  i_rd_data,
        output o_frame_ack,
        output o_rd_bank,
        output o_rd_en,
        output o_rd_addr
    );

    // Buffer / producer side
    modport slave (
        output i_frame_rdy,
        output i_rd_data,
        input  o_frame_ack,
        input  o_rd_bank,
        input  o_rd_en,
        input  o_rd_addr
    );
endinterface

// File: rtl/led_frame_sched.sv
// MiniLED frame scheduler: waits out driver configuration, then once per
// frame period raises sdbpflag and streams one brightness word per zone,
// reading the front bank of the zone ping-pong buffer. Banks swap only on
// a frame-start tick when the producer has a completed back bank.
module led_frame_sched #(
    parameter int ZONES    = 360,
    parameter int CFG_WAIT = 2500,
    parameter int PERIOD   = 420000,
    parameter int FLAG_W   = 30,
    parameter int ADDR_W   = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_enable,
    input  logic [1:0]           i_mode,
    input  logic [7:0]           i_gain,
    led_frame_sched_if.master    zbuf,
    output logic                 o_cfg_done,
    output logic                 o_sdbpflag,
    output logic                 o_wt_valid,
    output logic [ADDR_W-1:0]    o_wtaddr,
    output logic [15:0]          o_wtdina,
    output logic                 o_busy
);

    // One shared phase counter covers the config wait, flag, burst and drain
    localparam int CNT_MAX0 = (CFG_WAIT > FLAG_W) ? CFG_WAIT : FLAG_W;
    localparam int CNT_MAX  = (CNT_MAX0 > ZONES) ? CNT_MAX0 : ZONES;
    localparam int CNT_W    = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 2;
    localparam int PCNT_W   = (PERIOD > 2) ? $clog2(PERIOD) : 2;

    typedef enum logic [2:0] {
        S_CFG,
        S_IDLE,
        S_FLAG,
        S_BURST,
        S_DRAIN
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [PCNT_W-1:0]   r_pcnt;
    logic                r_cfg_done;
    logic                w_tick;
    logic                w_start;
    logic                w_cfg_end;
    logic                w_flag;
    logic                w_busy;
    logic                w_rd_en;

    logic [1:0]          r_mode;
    logic [7:0]          r_gain;
    logic                r_rd_bank;
    logic                r_ack;

    logic                r_v1;
    logic [ADDR_W-1:0]   r_a1;
    logic                r_wt_valid;
    logic [ADDR_W-1:0]   r_wtaddr;
    logic [15:0]         r_wtdina;
    logic [15:0]         w_word;

    assign w_tick = r_cfg_done && (r_pcnt == '0);

    // State and phase counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_CFG;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, counter advance and per-state strobes
    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt + 1'b1;
        w_start   = 1'b0;
        w_cfg_end = 1'b0;
        w_flag    = 1'b0;
        w_busy    = 1'b0;
        w_rd_en   = 1'b0;
        case (r_state)
            S_CFG: begin
                if (r_cnt == CNT_W'(CFG_WAIT - 1)) begin
                    w_cfg_end = 1'b1;
                    w_next    = S_IDLE;
                    w_cnt_nxt = '0;
                end
            end
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_tick && i_enable) begin
                    w_start = 1'b1;
                    w_next  = S_FLAG;
                end
            end
            S_FLAG: begin
                w_flag = 1'b1;
                w_busy = 1'b1;
                if (r_cnt == CNT_W'(FLAG_W - 1)) begin
                    w_next    = S_BURST;
                    w_cnt_nxt = '0;
                end
            end
            S_BURST: begin
                w_rd_en = 1'b1;
                w_busy  = 1'b1;
                if (r_cnt == CNT_W'(ZONES - 1)) begin
                    w_next    = S_DRAIN;
                    w_cnt_nxt = '0;
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_next    = S_IDLE;
                    w_cnt_nxt = '0;
                end
            end
            default: begin
                w_next    = S_CFG;
                w_cnt_nxt = '0;
            end
        endcase
    end

    // Sticky config-done flag and free-running frame period counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_done <= 1'b0;
            r_pcnt     <= '0;
        end else begin
            if (w_cfg_end) begin
                r_cfg_done <= 1'b1;
            end
            if (r_cfg_done) begin
                r_pcnt <= (r_pcnt == PCNT_W'(PERIOD - 1)) ? '0 : r_pcnt + 1'b1;
            end
        end
    end

    // Frame-start latch of mode/gain and the bank swap handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode    <= '0;
            r_gain    <= '0;
            r_rd_bank <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_ack <= w_start && zbuf.i_frame_rdy;
            if (w_start) begin
                r_mode <= i_mode;
                r_gain <= i_gain;
                if (zbuf.i_frame_rdy) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end
        end
    end

    // Brightness word for the grayscale value returned by the buffer
    always_comb begin
        w_word = '0;
        case (r_mode)
            2'b00:   w_word = 16'd57120;
            2'b01:   w_word = {8'd0, zbuf.i_rd_data} * 16'd255;
            2'b10:   w_word = {8'd0, zbuf.i_rd_data} * {8'd0, r_gain};
            default: w_word = 16'hFFFF;
        endcase
    end

    // Two-stage write pipeline: address tag waits one cycle for read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1       <= 1'b0;
            r_a1       <= '0;
            r_wt_valid <= 1'b0;
            r_wtaddr   <= '0;
            r_wtdina   <= '0;
        end else begin
            r_v1       <= w_rd_en;
            r_a1       <= ADDR_W'(r_cnt) + ADDR_W'(1);
            r_wt_valid <= r_v1;
            if (r_v1) begin
                r_wtaddr <= r_a1;
                r_wtdina <= w_word;
            end else begin
                r_wtaddr <= '0;
                r_wtdina <= '0;
            end
        end
    end

    assign zbuf.o_frame_ack = r_ack;
    assign zbuf.o_rd_bank   = r_rd_bank;
    assign zbuf.o_rd_en     = w_rd_en;
    assign zbuf.o_rd_addr   = w_rd_en ? ADDR_W'(r_cnt) : '0;

    assign o_cfg_done = r_cfg_done;
    assign o_sdbpflag = w_flag;
    assign o_busy     = w_busy;
    assign o_wt_valid = r_wt_valid;
    assign o_wtaddr   = r_wtaddr;
    assign o_wtdina   = r_wtdina;

endmodule
